alu_result_collector: RTL
=========================

# alu_result_collector

Output stage directly downstream of the ALU function-select decoder and the four execution units (arithmetic, logic, compare, shift). Each cycle, the decoder's one-hot unit enables select which unit's result is captured. Captured results go into a small FIFO and are presented to the consumer over a valid/ready handshake. The block also flags illegal enable patterns and counts delivered results.

## Interface
Parameters:
- OUT_WIDTH, 16, width of every unit result and of ALU_OUT
- FIFO_DEPTH, 4, result buffer entries; power of two, ≥ 2

Ports:
- CLK  input  1  single clock, rising edge
- RST  input  1  asynchronous, active-low reset
- IN_VALID  input  1  current cycle carries a result from the execution units
- IN_READY  output  1  collector can accept; equals !full
- Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  input  1 each  decoder one-hot enables
- Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  input  OUT_WIDTH each  unit results
- Carry_OUT  input  1  arithmetic carry/overflow bit
- OUT_VALID  output  1  head entry available; equals !empty
- OUT_READY  input  1  consumer accepts head entry
- ALU_OUT  output  OUT_WIDTH  head entry data
- ALU_CARRY  output  1  head entry carry
- ALU_SRC  output  2  head entry source: 00 arith, 01 logic, 10 cmp, 11 shift (same code as ALU_FUN_SEL)
- SEL_ERR  output  1  one-cycle pulse: an illegal enable pattern was dropped
- RESULT_CNT  output  16  count of delivered results; wraps

## Operation
- Accept occurs when IN_VALID && IN_READY on a rising CLK edge.
- Enables one-hot on an accept:
  - Push {ALU_SRC code, selected unit result, carry} at wr_ptr.
  - Carry = Carry_OUT only when Arith_Enable; otherwise 0.
- Enables zero-hot or multi-hot on an accept:
  - No push; pointers and count are unchanged.
  - SEL_ERR is high in the following cycle only.
- IN_VALID low: enables and data are ignored, and SEL_ERR is never raised.
- Pop occurs when OUT_VALID && OUT_READY; rd_ptr advances and RESULT_CNT increments.
- RESULT_CNT wraps from 0xFFFF to 0x0000.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Occupancy count is log2(FIFO_DEPTH)+1 bits; full means count == FIFO_DEPTH, empty means count == 0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- This case can only arise when the FIFO is neither full nor empty.
- Full FIFO: IN_READY is 0, so no push occurs, even if OUT_READY is high in that cycle (no pass-through).
- Empty FIFO: OUT_VALID is 0, and ALU_OUT, ALU_CARRY and ALU_SRC are driven to 0.
- Non-empty FIFO: ALU_OUT, ALU_CARRY and ALU_SRC present mem[rd_ptr], read combinationally from the storage registers.
- Data is bit-transparent: no sign extension and no modification. Signed interpretation belongs to the consumer.
- Reset (RST low, asynchronous, any time including mid-transfer), applied immediately:
  - All buffered entries are discarded.
  - Pointers, count and RESULT_CNT are cleared to 0, and SEL_ERR is cleared to 0.
  - Storage contents are don't-care.

## Timing
Reset values:
- IN_READY = 1, OUT_VALID = 0.
- ALU_OUT = 0, ALU_CARRY = 0, ALU_SRC = 00.
- SEL_ERR = 0, RESULT_CNT = 0.

Latency and flags:
- Accept at edge N makes the entry visible on the outputs after edge N (OUT_VALID high in cycle N+1). Minimum latency is 1 cycle.
- The head entry is stable while OUT_VALID && !OUT_READY.
- IN_READY and OUT_VALID are decoded from the registered count only. Neither has a combinational path from IN_VALID or OUT_READY.
- SEL_ERR asserts the cycle after the offending accept and lasts one cycle per offending accept. Back-to-back errors keep it high continuously.
- RESULT_CNT updates on the edge of the pop.

Throughput: one push and one pop per cycle sustained.

Reset release: the first accept is possible on the first rising edge after RST goes high.

## Test plan
- **Single result:** reset, then IN_VALID=1, Arith_Enable=1, Arith_OUT=0xFFF6, Carry_OUT=1 for one cycle, with OUT_READY=1.
  - Next cycle: OUT_VALID=1, ALU_OUT=0xFFF6, ALU_CARRY=1, ALU_SRC=00.
  - Cycle after: OUT_VALID=0 and RESULT_CNT=1.
- **Fill to full:** OUT_READY=0, push 4 shift results 0x0001..0x0004.
  - IN_READY drops after the 4th accept, and a 5th IN_VALID is not accepted.
  - Then OUT_READY=1: outputs 0x0001..0x0004 appear in order with ALU_SRC=11, and IN_READY rises after the first pop.
- **Simultaneous push/pop:** with 2 entries held, drive continuous push and pop for 10 cycles.
  - Count stays at 2, data order is preserved, pointers wrap past FIFO_DEPTH, and RESULT_CNT rises by 10.
- **Illegal enables:** IN_VALID=1 with Arith_Enable=Logic_Enable=1, then IN_VALID=1 with all enables 0.
  - SEL_ERR is high for 2 consecutive cycles, nothing is pushed, and OUT_VALID stays 0.
  - Also: all enables 0 with IN_VALID=0 gives SEL_ERR=0.
- **Carry masking:** Logic_Enable=1, Logic_OUT=0x00F0, Carry_OUT=1 → entry has ALU_CARRY=0, ALU_SRC=01.
- **Reset mid-stream and counter wrap:**
  - Mid-stream: with 3 entries held, pulse RST low between clock edges → outputs go to reset values immediately, and after release the FIFO is empty.
  - Wrap: force 65536 pops → RESULT_CNT returns to 0x0000.

Source files
------------

// File: rtl/alu_result_collector.sv
// alu_result_collector: captures the one-hot selected execution-unit result into a small FIFO
// and presents it over valid/ready, flagging illegal enable patterns and counting deliveries.
module alu_result_collector #(
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 Arith_Enable,
  input  logic                 Logic_Enable,
  input  logic                 CMP_Enable,
  input  logic                 Shift_Enable,
  input  logic [OUT_WIDTH-1:0] Arith_OUT,
  input  logic [OUT_WIDTH-1:0] Logic_OUT,
  input  logic [OUT_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_WIDTH-1:0] Shift_OUT,
  input  logic                 Carry_OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [OUT_WIDTH-1:0] ALU_OUT,
  output logic                 ALU_CARRY,
  output logic [1:0]           ALU_SRC,
  output logic                 SEL_ERR,
  output logic [15:0]          RESULT_CNT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = OUT_WIDTH + 3;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [AW:0]          r_cnt;
  logic                 r_err;
  logic [15:0]          r_res;
  logic [3:0]           w_en;
  logic                 w_onehot;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           w_src;
  logic [OUT_WIDTH-1:0] w_data;
  logic [EW-1:0]        w_head;
  assign w_en     = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
  assign w_onehot = (w_en != 4'd0) && ((w_en & (w_en - 4'd1)) == 4'd0);
  assign w_src    = Arith_Enable ? 2'd0 : Logic_Enable ? 2'd1 : CMP_Enable ? 2'd2 : 2'd3;
  assign w_data   = Arith_Enable ? Arith_OUT : Logic_Enable ? Logic_OUT : CMP_Enable ? CMP_OUT : Shift_OUT;
  // Handshake flags come only from the registered occupancy, never from the partner's strobe.
  assign IN_READY  = r_cnt != (AW+1)'(FIFO_DEPTH);
  assign OUT_VALID = r_cnt != '0;
  assign w_accept  = IN_VALID && IN_READY;
  assign w_push    = w_accept && w_onehot;
  assign w_pop     = OUT_VALID && OUT_READY;
  assign w_head    = OUT_VALID ? r_mem[r_rd] : '0;
  assign {ALU_SRC, ALU_OUT, ALU_CARRY} = w_head;
  assign SEL_ERR    = r_err;
  assign RESULT_CNT = r_res;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_res <= '0;
    end else begin
      r_wr  <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd  <= w_pop ? r_rd + AW'(1) : r_rd;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_err <= w_accept && !w_onehot;
      r_res <= r_res + 16'(w_pop);
    end
  end
  // Storage needs no reset: entries are only observable through the count.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= {w_src, w_data, Arith_Enable & Carry_OUT};
  end
endmodule
